// File: rtl/ula_datapath.sv
// Execution datapath behind the op scheduler: X/Y/Z operand registers plus one
// combinational ALU. Y accumulates ALU results, Z latches Y for display.
module ula_datapath #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [3:0]       Tx,
    input  logic [3:0]       Ty,
    input  logic [3:0]       Tz,
    input  logic [3:0]       Tula,
    output logic [WIDTH-1:0] x_q,
    output logic [WIDTH-1:0] y_q,
    output logic [WIDTH-1:0] z_q,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry
);

    localparam logic [3:0] RegHold   = 4'b0000;
    localparam logic [3:0] RegLoad   = 4'b0001;
    localparam logic [3:0] RegShiftR = 4'b0010;
    localparam logic [3:0] RegShiftL = 4'b0011;
    localparam logic [3:0] RegClear  = 4'b0100;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;

    logic [WIDTH-1:0] r_x, r_y, r_z;
    logic             r_carry;

    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_alu;
    logic             w_cout;
    logic [WIDTH-1:0] w_x_next, w_y_next, w_z_next;

    // Shared next-value decode for all three registers; unknown codes hold.
    function automatic logic [WIDTH-1:0] f_reg_next(input logic [3:0]       i_code,
                                                    input logic [WIDTH-1:0] i_cur,
                                                    input logic [WIDTH-1:0] i_load);
        logic [WIDTH-1:0] v;
        case (i_code)
            RegHold:   v = i_cur;
            RegLoad:   v = i_load;
            RegShiftR: v = {1'b0, i_cur[WIDTH-1:1]};
            RegShiftL: v = {i_cur[WIDTH-2:0], 1'b0};
            RegClear:  v = '0;
            default:   v = i_cur;
        endcase
        return v;
    endfunction

    // Borrow falls out as the top bit of the (WIDTH+1)-bit difference.
    always_comb begin
        w_sum  = {1'b0, r_y} + {1'b0, r_x};
        w_diff = {1'b0, r_y} - {1'b0, r_x};
        w_alu  = r_x;
        w_cout = 1'b0;
        case (Tula)
            AluAdd: begin
                w_alu  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
            end
            AluSub: begin
                w_alu  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
            end
            AluAnd:  w_alu = r_x & r_y;
            AluOr:   w_alu = r_x | r_y;
            default: w_alu = r_x;
        endcase
    end

    always_comb begin
        w_x_next = f_reg_next(Tx, r_x, din);
        w_y_next = f_reg_next(Ty, r_y, w_alu);
        w_z_next = f_reg_next(Tz, r_z, r_y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
        end else begin
            r_x <= w_x_next;
            r_y <= w_y_next;
            r_z <= w_z_next;
            // Carry tracks only ALU results that actually land in Y.
            if (Ty == RegLoad) begin
                r_carry <= w_cout;
            end
        end
    end

    assign x_q     = r_x;
    assign y_q     = r_y;
    assign z_q     = r_z;
    assign alu_out = w_alu;
    assign carry   = r_carry;

endmodule

// File: tb/tb_ula_datapath.sv
// Scoreboard bench for ula_datapath: directed steps push expected register state,
// a monitor pops and compares one entry after each rising edge.
module tb_ula_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din, Tx, Ty, Tz, Tula;
    logic [3:0] x_q, y_q, z_q, alu_out;
    logic       carry;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
        logic       c;
        logic       chk_alu;
        logic [3:0] alu;
        logic [7:0] id;
    } exp_t;

    exp_t exp_q[$];

    ula_datapath #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .Tx      (Tx),
        .Ty      (Ty),
        .Tz      (Tz),
        .Tula    (Tula),
        .x_q     (x_q),
        .y_q     (y_q),
        .z_q     (z_q),
        .alu_out (alu_out),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    // Drive at the falling edge; the result is due after the next rising edge.
    task automatic step(input logic r, input logic [3:0] d, input logic [3:0] tx,
                        input logic [3:0] ty, input logic [3:0] tz, input logic [3:0] tu,
                        input logic [3:0] ex, input logic [3:0] ey, input logic [3:0] ez,
                        input logic ec, input logic ca, input logic [3:0] ea,
                        input logic [7:0] id);
        exp_t e;
        @(negedge clk);
        rst = r; din = d; Tx = tx; Ty = ty; Tz = tz; Tula = tu;
        e.x = ex; e.y = ey; e.z = ez; e.c = ec; e.chk_alu = ca; e.alu = ea; e.id = id;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (x_q !== e.x || y_q !== e.y || z_q !== e.z || carry !== e.c) begin
                    failures++;
                    $display("FAIL step%0d regs: got x=%0d y=%0d z=%0d c=%0b want x=%0d y=%0d z=%0d c=%0b",
                             e.id, x_q, y_q, z_q, carry, e.x, e.y, e.z, e.c);
                end
                if (e.chk_alu) begin
                    checks++;
                    if (alu_out !== e.alu) begin
                        failures++;
                        $display("FAIL step%0d alu_out: got %0d want %0d", e.id, alu_out, e.alu);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; din = '0; Tx = '0; Ty = '0; Tz = '0; Tula = '0;
        //    rst din  Tx  Ty  Tz  Tula   X   Y   Z  c  alu?  alu  id
        step(1, 5,   1,  1,  1,  0,      0,  0,  0, 0, 0,    0,   1);  // reset beats LOAD
        step(0, 3,   1,  4,  4,  0,      3,  0,  0, 0, 0,    0,   2);  // CLEARLD
        step(0, 0,   0,  1,  0,  0,      3,  3,  0, 0, 0,    0,   3);  // ADD
        step(0, 0,   0,  1,  0,  0,      3,  6,  0, 0, 0,    0,   4);  // ADD
        step(0, 0,   0,  0,  1,  0,      3,  6,  6, 0, 0,    0,   5);  // DISP
        step(0, 0,   0,  2,  1,  0,      3,  3,  6, 0, 0,    0,   6);  // SHTR + DISP old Y
        step(0, 0,   0,  1,  0,  0,      3,  6,  6, 0, 0,    0,   7);  // ADD
        step(0, 9,   1,  1,  0,  0,      9,  9,  6, 0, 0,    0,   8);  // ADDLD old operands
        step(0, 0,   0,  1,  0,  0,      9,  2,  6, 1, 0,    0,   9);  // 9+9 overflow
        step(0, 0,   0,  0,  0,  0,      9,  2,  6, 1, 0,    0,  10);  // HOLD keeps carry
        step(0, 0,   0,  4,  0,  0,      9,  0,  6, 1, 0,    0,  11);  // CLEAR keeps carry
        step(0, 5,   1,  0,  0,  0,      5,  0,  6, 1, 0,    0,  12);
        step(0, 0,   0,  1,  0, 15,      5,  5,  6, 0, 0,    0,  13);  // pass-X ALU
        step(0, 2,   1,  0,  0,  0,      2,  5,  6, 0, 0,    0,  14);
        step(0, 0,   0,  1,  0,  1,      2,  3,  6, 0, 0,    0,  15);  // SUB 5-2
        step(0, 0,   0,  1,  0,  2,      2,  2,  6, 0, 0,    0,  16);  // AND 2&3
        step(0, 5,   1,  0,  0,  0,      5,  2,  6, 0, 0,    0,  17);
        step(0, 0,   0,  1,  0,  1,      5, 13,  6, 1, 0,    0,  18);  // SUB borrow
        step(0, 0,   0,  0,  0,  0,      5, 13,  6, 1, 0,    0,  19);  // HOLD keeps borrow
        step(0, 0,   0,  2,  0,  0,      5,  6,  6, 1, 0,    0,  20);  // SHIFTR
        step(0, 0,   0,  2,  0,  0,      5,  3,  6, 1, 0,    0,  21);  // SHIFTR
        step(0, 13,  1,  0,  0,  0,     13,  3,  6, 1, 0,    0,  22);
        step(0, 0,   0,  1,  0, 15,     13, 13,  6, 0, 0,    0,  23);
        step(0, 0,   0,  3,  0,  0,     13, 10,  6, 0, 0,    0,  24);  // SHIFTL drops MSB
        step(0, 8,   1,  0,  0,  0,      8, 10,  6, 0, 0,    0,  25);
        step(0, 0,   2,  0,  0,  0,      4, 10,  6, 0, 0,    0,  26);  // X SHIFTR
        step(0, 0,   0,  1,  0,  3,      4, 14,  6, 0, 0,    0,  27);  // OR 4|10
        step(0, 0,   3,  0,  0,  0,      8, 14,  6, 0, 0,    0,  28);  // X SHIFTL
        step(0, 0,   0,  0,  2,  0,      8, 14,  3, 0, 0,    0,  29);  // Z SHIFTR
        step(0, 0,   0,  0,  4,  0,      8, 14,  0, 0, 0,    0,  30);  // Z CLEAR
        step(0, 7,  15, 15, 15, 15,      8, 14,  0, 0, 1,    8,  31);  // illegal codes hold
        step(0, 0,   0,  1,  0,  0,      8,  6,  0, 1, 0,    0,  32);  // 8+14 overflow
        step(1, 7,   1,  1,  1,  0,      0,  0,  0, 0, 0,    0,  33);  // reset mid-LOAD
        step(0, 6,   1,  1,  0,  0,      6,  0,  0, 0, 1,    6,  34);  // first edge after rst
        step(0, 0,   0,  1,  1,  0,      6,  6,  0, 0, 1,   12,  35);  // ADD, alu live
        step(0, 0,   0,  0,  0,  0,      6,  6,  0, 0, 0,    0,  36);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
